conv_enc: RTL and testbench

- Rate-1/2 feed-forward convolutional encoder, directly downstream of the clock divider.
- Consumes one information bit per rising edge of the divided bit-rate signal and produces one coded pair per consumed bit.
- Serializes each pair onto a single-bit channel at the system clock rate.
- Optionally appends K-1 zero tail bits to terminate each frame in the all-zero state.

---
 rtl/conv_enc_pkg.sv | 19 +
 rtl/conv_enc_ser.sv | 36 +++
 rtl/conv_enc.sv | 150 +++++++++++++++
 tb/tb_conv_enc.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_enc_pkg.sv
// Shared types and defaults for the rate-1/2 convolutional encoder.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } enc_state_t;

    localparam int         CONV_K  = 3;
    localparam logic [2:0] CONV_G0 = 3'o7;
    localparam logic [2:0] CONV_G1 = 3'o5;

    // Even/odd parity of a tapped shift-register vector (zero-extended to 16 bits).
    function automatic logic parity(input logic [15:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/conv_enc_ser.sv
// 2-bit parallel-to-serial stage: c0 in the cycle after load, c1 in the next.
module conv_ser (
    input  logic       clk_sig,
    input  logic       rst_sig,
    input  logic       load,
    input  logic [1:0] pair,
    output logic       ser_out,
    output logic       ser_valid
);

    logic c1_q;
    logic pending_q;

    // Shift the loaded pair out MSB first, holding c1 for the second cycle.
    always_ff @(posedge clk_sig) begin
        if (rst_sig) begin
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            c1_q      <= 1'b0;
            pending_q <= 1'b0;
        end else if (load) begin
            ser_out   <= pair[1];
            ser_valid <= 1'b1;
            c1_q      <= pair[0];
            pending_q <= 1'b1;
        end else if (pending_q) begin
            ser_out   <= c1_q;
            ser_valid <= 1'b1;
            pending_q <= 1'b0;
        end else begin
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/conv_enc.sv
// Rate-1/2 feed-forward convolutional encoder with single-bit serial output.
// Define CONV_ENC_TAIL_EN to append K-1 zero tail bits after each frame.
module conv_enc
    import conv_pkg::*;
#(
    parameter int         K  = CONV_K,
    parameter logic [K-1:0] G0 = CONV_G0,
    parameter logic [K-1:0] G1 = CONV_G1
) (
    input  logic       clk_sig,
    input  logic       rst_sig,
    input  logic       div_sig,
    input  logic       din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    output logic [1:0] code_bits,
    output logic       code_valid,
    output logic       code_last,
    output logic       ser_out,
    output logic       ser_valid
);

`ifdef CONV_ENC_TAIL_EN
    localparam int TCW = $clog2(K);
    logic [TCW-1:0] tail_cnt_q;
    logic [TCW-1:0] tail_cnt_d;
`endif

    enc_state_t   state_q;
    enc_state_t   state_d;
    logic [K-2:0] sr_q;
    logic [K-1:0] v;
    logic         div_d;
    logic         div_armed;
    logic         tick;
    logic         encode;
    logic         u;
    logic         last_pair;
    logic         c0;
    logic         c1;

    // div_armed stays low until div_sig is seen low, so a level already high
    // at reset release cannot produce a tick.
    assign tick = div_sig & ~div_d & div_armed;

    assign v  = {u, sr_q};
    assign c0 = parity(16'(v & G0));
    assign c1 = parity(16'(v & G1));

    // Rising-edge detector history for the divided bit-rate signal.
    always_ff @(posedge clk_sig) begin
        if (rst_sig) begin
            div_d     <= 1'b0;
            div_armed <= 1'b0;
        end else begin
            div_d <= div_sig;
            if (!div_sig) begin
                div_armed <= 1'b1;
            end
        end
    end

    // FSM state register (and tail counter when tail termination is built in).
    always_ff @(posedge clk_sig) begin
        if (rst_sig) begin
            state_q    <= IDLE;
`ifdef CONV_ENC_TAIL_EN
            tail_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
`ifdef CONV_ENC_TAIL_EN
            tail_cnt_q <= tail_cnt_d;
`endif
        end
    end

    // Next state, input handshake and encode decision for the current tick.
    always_comb begin
        state_d   = state_q;
        encode    = 1'b0;
        u         = 1'b0;
        last_pair = 1'b0;
        din_ready = 1'b0;
`ifdef CONV_ENC_TAIL_EN
        tail_cnt_d = tail_cnt_q;
`endif
        case (state_q)
            IDLE, DATA: begin
                din_ready = tick;
                if (tick && din_valid) begin
                    encode = 1'b1;
                    u      = din;
`ifdef CONV_ENC_TAIL_EN
                    if (din_last) begin
                        state_d    = TAIL;
                        tail_cnt_d = TCW'(K - 1);
                    end else begin
                        state_d = DATA;
                    end
`else
                    last_pair = din_last;
                    state_d   = din_last ? IDLE : DATA;
`endif
                end
            end
`ifdef CONV_ENC_TAIL_EN
            TAIL: begin
                if (tick) begin
                    encode     = 1'b1;
                    tail_cnt_d = tail_cnt_q - TCW'(1);
                    if (tail_cnt_q == TCW'(1)) begin
                        last_pair = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Shift register update and registered coded pair.
    always_ff @(posedge clk_sig) begin
        if (rst_sig) begin
            sr_q       <= '0;
            code_bits  <= '0;
            code_valid <= 1'b0;
            code_last  <= 1'b0;
        end else begin
            code_valid <= encode;
            code_last  <= last_pair;
            if (encode) begin
                sr_q      <= {u, sr_q[K-2:1]};
                code_bits <= {c0, c1};
            end
        end
    end

    conv_ser u_ser (
        .clk_sig   (clk_sig),
        .rst_sig   (rst_sig),
        .load      (code_valid),
        .pair      (code_bits),
        .ser_out   (ser_out),
        .ser_valid (ser_valid)
    );

endmodule

// File: tb/tb_conv_enc.sv
// Directed bench for conv_enc (K=3, G=7/5, divider NUM=4); honours CONV_ENC_TAIL_EN.
module tb_conv_enc;

    logic       clk_sig = 1'b0;
    logic       rst_sig = 1'b1;
    logic       div_sig = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       din_last = 1'b0;
    logic       din_ready;
    logic [1:0] code_bits;
    logic       code_valid;
    logic       code_last;
    logic       ser_out;
    logic       ser_valid;

    int checks = 0;
    int errors = 0;

    logic [2:0] pq[$];
    logic       sq[$];
    logic [2:0] exp_p[$];
    logic       exp_s[$];
    logic       tail_rdy;

    conv_enc #(.K(3), .G0(3'o7), .G1(3'o5)) dut (
        .clk_sig    (clk_sig),
        .rst_sig    (rst_sig),
        .div_sig    (div_sig),
        .din        (din),
        .din_valid  (din_valid),
        .din_last   (din_last),
        .din_ready  (din_ready),
        .code_bits  (code_bits),
        .code_valid (code_valid),
        .code_last  (code_last),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid)
    );

    always #5 clk_sig = ~clk_sig;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; log {code_last,code_bits} on code_valid and ser_out on ser_valid.
    task automatic clk1();
        @(posedge clk_sig);
        #1;
        if (code_valid === 1'b1) pq.push_back({code_last, code_bits});
        if (ser_valid === 1'b1) sq.push_back(ser_out);
    endtask

    // One NUM=4 bit period: tick cycle, high cycle, two low cycles.
    task automatic slot(input logic v, input logic d, input logic l, input logic rdy_exp);
        div_sig = 1'b1; din_valid = v; din = d; din_last = l;
        #1;
        chk("din_ready", {7'd0, din_ready}, {7'd0, rdy_exp});
        clk1();
        div_sig = 1'b1; din_valid = 1'b0;
        clk1();
        div_sig = 1'b0;
        clk1();
        clk1();
    endtask

    task automatic do_reset();
        rst_sig = 1'b1; div_sig = 1'b0; din_valid = 1'b0; din = 1'b0; din_last = 1'b0;
        clk1();
        clk1();
        rst_sig = 1'b0;
        clk1();
        pq.delete();
        sq.delete();
    endtask

    task automatic chk_pairs(input string tag);
        logic [2:0] obs;
        chk({tag, "_npairs"}, 8'(pq.size()), 8'(exp_p.size()));
        for (int i = 0; i < exp_p.size(); i++) begin
            obs = (i < pq.size()) ? pq[i] : 3'bxxx;
            chk($sformatf("%s_pair%0d", tag, i), {5'd0, obs}, {5'd0, exp_p[i]});
        end
    endtask

    task automatic chk_ser(input string tag);
        logic obs;
        chk({tag, "_nser"}, 8'(sq.size()), 8'(exp_s.size()));
        for (int i = 0; i < exp_s.size(); i++) begin
            obs = (i < sq.size()) ? sq[i] : 1'bx;
            chk($sformatf("%s_ser%0d", tag, i), {7'd0, obs}, {7'd0, exp_s[i]});
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_code_bits"}, {6'd0, code_bits}, 8'd0);
        chk({tag, "_code_valid"}, {7'd0, code_valid}, 8'd0);
        chk({tag, "_code_last"}, {7'd0, code_last}, 8'd0);
        chk({tag, "_ser_out"}, {7'd0, ser_out}, 8'd0);
        chk({tag, "_ser_valid"}, {7'd0, ser_valid}, 8'd0);
    endtask

    // Frame 1,0,1,1 followed by two idle slots (tail slots when the tail is built in).
    task automatic frame_1011();
        slot(1'b1, 1'b1, 1'b0, 1'b1);
        slot(1'b1, 1'b0, 1'b0, 1'b1);
        slot(1'b1, 1'b1, 1'b0, 1'b1);
        slot(1'b1, 1'b1, 1'b1, 1'b1);
        slot(1'b0, 1'b0, 1'b0, tail_rdy);
        slot(1'b0, 1'b0, 1'b0, tail_rdy);
    endtask

    task automatic set_frame_exp();
`ifdef CONV_ENC_TAIL_EN
        exp_p = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111};
        exp_s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`else
        exp_p = '{3'b011, 3'b010, 3'b000, 3'b101};
        exp_s = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
    endtask

    initial begin
`ifdef CONV_ENC_TAIL_EN
        tail_rdy = 1'b0;
`else
        tail_rdy = 1'b1;
`endif
        // Reset state.
        rst_sig = 1'b1;
        clk1();
        chk_zero("reset");
        do_reset();

        // Basic frame.
        frame_1011();
        set_frame_exp();
        chk_pairs("frame");
        chk_ser("frame");

        // Two bubbles between bits 2 and 3 leave the coded sequence unchanged.
        do_reset();
        slot(1'b1, 1'b1, 1'b0, 1'b1);
        slot(1'b1, 1'b0, 1'b0, 1'b1);
        slot(1'b0, 1'b0, 1'b0, 1'b1);
        slot(1'b0, 1'b0, 1'b0, 1'b1);
        slot(1'b1, 1'b1, 1'b0, 1'b1);
        slot(1'b1, 1'b1, 1'b1, 1'b1);
        slot(1'b0, 1'b0, 1'b0, tail_rdy);
        slot(1'b0, 1'b0, 1'b0, tail_rdy);
        set_frame_exp();
        chk_pairs("bubble");
        chk_ser("bubble");

        // Reset while the second pair is being serialized.
        do_reset();
        slot(1'b1, 1'b1, 1'b0, 1'b1);
        div_sig = 1'b1; din_valid = 1'b1; din = 1'b0; din_last = 1'b0;
        clk1();
        div_sig = 1'b1; din_valid = 1'b0;
        clk1();
        chk("midser_ser_valid", {7'd0, ser_valid}, 8'd1);
        rst_sig = 1'b1;
        clk1();
        chk_zero("midrst");
        do_reset();
        frame_1011();
        set_frame_exp();
        chk_pairs("postrst");

        // din_valid held high through the tail; bit taken after return to IDLE.
        do_reset();
        slot(1'b1, 1'b1, 1'b0, 1'b1);
        slot(1'b1, 1'b0, 1'b0, 1'b1);
        slot(1'b1, 1'b1, 1'b0, 1'b1);
        slot(1'b1, 1'b1, 1'b1, 1'b1);
        slot(1'b1, 1'b1, 1'b0, tail_rdy);
        slot(1'b1, 1'b1, 1'b0, tail_rdy);
        slot(1'b1, 1'b1, 1'b0, 1'b1);
`ifdef CONV_ENC_TAIL_EN
        exp_p = '{3'b011, 3'b010, 3'b000, 3'b001, 3'b001, 3'b111, 3'b011};
`else
        exp_p = '{3'b011, 3'b010, 3'b000, 3'b101, 3'b010, 3'b010, 3'b010};
`endif
        chk_pairs("tailvalid");

        // Frames 1,1 then 1: state carried across frames unless the tail flushes it.
        do_reset();
        slot(1'b1, 1'b1, 1'b0, 1'b1);
        slot(1'b1, 1'b1, 1'b1, 1'b1);
        slot(1'b0, 1'b0, 1'b0, tail_rdy);
        slot(1'b0, 1'b0, 1'b0, tail_rdy);
        slot(1'b1, 1'b1, 1'b0, 1'b1);
`ifdef CONV_ENC_TAIL_EN
        exp_p = '{3'b011, 3'b001, 3'b001, 3'b111, 3'b011};
`else
        exp_p = '{3'b011, 3'b101, 3'b010};
`endif
        chk_pairs("carry");

        // div_sig high through reset release: no tick until its next rising edge.
        rst_sig = 1'b1; div_sig = 1'b1; din_valid = 1'b1; din = 1'b1; din_last = 1'b0;
        clk1();
        clk1();
        rst_sig = 1'b0;
        pq.delete();
        sq.delete();
        #1;
        chk("divhigh_ready", {7'd0, din_ready}, 8'd0);
        clk1();
        clk1();
        clk1();
        chk("divhigh_ready2", {7'd0, din_ready}, 8'd0);
        div_sig = 1'b0; din_valid = 1'b0;
        clk1();
        chk("divhigh_npairs", 8'(pq.size()), 8'd0);
        slot(1'b1, 1'b1, 1'b0, 1'b1);
        exp_p = '{3'b011};
        chk_pairs("divhigh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
